// File: rtl/lcd_bcd_converter.sv
// Binary-to-BCD converter for the LCD output path: iterative double-dabble,
// one input bit per clock, with a one-entry pending buffer for back-to-back writes.
module lcd_bcd_converter #(
    parameter int WIDTH       = 32,
    parameter int DIGITS      = 10,
    parameter int SIGNED_MODE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    din,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                neg,
    output logic [3:0]          ndig,
    output logic                overrun
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_negative(input logic [WIDTH-1:0] v);
        return (SIGNED_MODE != 0) && v[WIDTH-1];
    endfunction

    // Plain WIDTH-bit negate, so the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (is_negative(v)) begin
            m = ~v + WIDTH'(1);
        end else begin
            m = v;
        end
        return m;
    endfunction

    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] a);
        logic [BW-1:0] r;
        r = a;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = a[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] count_digits(input logic [BW-1:0] a);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] != 4'd0) begin
                n = 4'(i + 1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]    acc_q, acc_d;
    logic             sign_q, sign_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_din_q, pend_din_d;
    logic             pend_vld_q, pend_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic [3:0]       ndig_q, ndig_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] ld_src_s;
    logic             load_s;
    logic [SW-1:0]    sh_s;

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        acc_d      = acc_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        pend_din_d = pend_din_q;
        pend_vld_d = pend_vld_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        ndig_d     = ndig_q;
        overrun_d  = overrun_q;
        load_s     = 1'b0;
        sh_s       = '0;
        // A fresh strobe in DONE wins over the buffered request: newest data is converted.
        if ((state_q == ST_DONE) && !start) begin
            ld_src_s = pend_din_q;
        end else begin
            ld_src_s = din;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                sh_s  = {add3_digits(acc_q), mag_q};
                acc_d = sh_s[SW-2:WIDTH-1];
                mag_d = {sh_s[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
                if (start) begin
                    pend_din_d = din;
                    pend_vld_d = 1'b1;
                    overrun_d  = overrun_q | pend_vld_q;
                end else begin
                    pend_din_d = pend_din_q;
                end
            end
            ST_DONE: begin
                bcd_d  = acc_q;
                neg_d  = sign_q;
                ndig_d = count_digits(acc_q);
                done_d = 1'b1;
                if (start || pend_vld_q) begin
                    load_s     = 1'b1;
                    pend_vld_d = 1'b0;
                    overrun_d  = overrun_q | (start & pend_vld_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            mag_d   = magnitude(ld_src_s);
            sign_d  = is_negative(ld_src_s);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_SHIFT;
        end else begin
            mag_d = mag_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mag_q      <= '0;
            acc_q      <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            pend_din_q <= '0;
            pend_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            ndig_q     <= 4'd1;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            acc_q      <= acc_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            pend_din_q <= pend_din_d;
            pend_vld_q <= pend_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            ndig_q     <= ndig_d;
            overrun_q  <= overrun_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd     = bcd_q;
    assign neg     = neg_q;
    assign ndig    = ndig_q;
    assign overrun = overrun_q;

endmodule
